trivium_ctrl: RTL

TRIVIUM_CTRL -- requirements
Module: trivium_ctrl

---
 rtl/trivium_ctrl_if.sv | 23 ++
 rtl/trivium_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/trivium_ctrl_if.sv
// Word-stream handshake between a plaintext producer / ciphertext consumer
// and the Trivium controller.
//   in_dat_i/in_valid_i/in_ready_o    : plaintext word in, valid/ready
//   out_dat_o/out_valid_o/out_ready_i : ciphertext word out, valid/ready
// Signal suffixes are from the controller's point of view (slave modport).
interface trivium_ctrl_if;
  logic [31:0] in_dat_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] out_dat_o;
  logic        out_valid_o;
  logic        out_ready_i;

  modport master (
    output in_dat_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_dat_o, out_valid_o
  );

  modport slave (
    input  in_dat_i, in_valid_i, out_ready_i,
    output in_ready_o, out_dat_o, out_valid_o
  );
endinterface

// File: rtl/trivium_ctrl.sv
// Sequencer for a bit-serial Trivium core: loads key and IV serially,
// waits for the core's warm-up, then encrypts 32-bit words one bit per
// cycle and hands the ciphertext word out with a valid/ready handshake.
// Ports:
//   clk_i, n_rst_i      : clock, asynchronous active-low reset
//   key_i, iv_i         : 80-bit key / IV, captured when start_i is accepted
//   start_i, stop_i     : begin a session (IDLE/ERR), end it (READY)
//   idle_o, err_o       : idle indication, sticky warm-up timeout flag
//   strm                : plaintext/ciphertext word stream (slave side)
//   core_dat_o/init_o/end_o/vld_o : serial data and controls to the core
//   core_dat_i, core_busy_i       : serial result and warm-up busy from core
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no session; waits for start_i
// LOAD_KEY  | 80 cycles, key bits LSB-first with core_init_o=1
// LOAD_IV   | 80 cycles, IV bits LSB-first with core_init_o=1
// WAIT_INIT | core warming up; leave on busy low or on timeout
// READY     | in_ready_o=1; accepts a word or stop_i
// SHIFT     | strobes 32 bits into the core, collects the results
// HOLD      | ciphertext word presented until out_ready_i
// END       | one-cycle core_end_o pulse
// ERR       | warm-up timed out; err_o=1 until the next start_i
module trivium_ctrl #(
  parameter int CORE_LAT     = 1,
  parameter int INIT_TIMEOUT = 1300
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic [79:0] key_i,
  input  logic [79:0] iv_i,
  input  logic        start_i,
  input  logic        stop_i,
  output logic        idle_o,
  output logic        err_o,
  trivium_ctrl_if.slave strm,
  output logic        core_dat_o,
  output logic        core_init_o,
  output logic        core_end_o,
  output logic        core_vld_o,
  input  logic        core_dat_i,
  input  logic        core_busy_i
);

  localparam int              TW         = $clog2(INIT_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMR_LOAD   = TW'(INIT_TIMEOUT - 1);
  localparam logic [7:0]      SHIFT_LAST = 8'(31 + CORE_LAT);
  localparam logic [7:0]      CAP_FIRST  = 8'(CORE_LAT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_KEY, S_LOAD_IV, S_WAIT_INIT, S_READY,
    S_SHIFT, S_HOLD, S_END, S_ERR
  } state_t;

  state_t         state;
  logic [7:0]     cnt;
  logic [TW-1:0]  tmr;
  logic [159:0]   ld_sr;
  logic [31:0]    word_sr;
  logic           core_q;
  logic           idle_q, err_q, in_ready_q, out_valid_q;
  logic [31:0]    out_dat_q;
  logic           core_dat_q, core_init_q, core_end_q, core_vld_q;

  assign idle_o          = idle_q;
  assign err_o           = err_q;
  assign strm.in_ready_o  = in_ready_q;
  assign strm.out_valid_o = out_valid_q;
  assign strm.out_dat_o   = out_dat_q;
  assign core_dat_o      = core_dat_q;
  assign core_init_o     = core_init_q;
  assign core_end_o      = core_end_q;
  assign core_vld_o      = core_vld_q;

  // Outputs are loaded together with the state they belong to, so the pins
  // always describe the current state's cycle.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      tmr         <= '0;
      ld_sr       <= '0;
      word_sr     <= '0;
      core_q      <= 1'b0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_dat_q   <= '0;
      core_dat_q  <= 1'b0;
      core_init_q <= 1'b0;
      core_end_q  <= 1'b0;
      core_vld_q  <= 1'b0;
    end else begin
      // Core result is retimed by one flop before entering the word, which
      // is why the last bit lands during the first HOLD cycle.
      core_q <= core_dat_i;
      case (state)
        S_IDLE, S_ERR: begin
          if (start_i) begin
            state       <= S_LOAD_KEY;
            cnt         <= '0;
            idle_q      <= 1'b0;
            err_q       <= 1'b0;
            core_init_q <= 1'b1;
            core_dat_q  <= key_i[0];
            ld_sr       <= {1'b0, iv_i, key_i[79:1]};
          end
        end
        S_LOAD_KEY: begin
          core_dat_q <= ld_sr[0];
          ld_sr      <= {1'b0, ld_sr[159:1]};
          if (cnt == 8'd79) begin
            state <= S_LOAD_IV;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_LOAD_IV: begin
          if (cnt == 8'd79) begin
            state       <= S_WAIT_INIT;
            cnt         <= '0;
            tmr         <= TMR_LOAD;
            core_init_q <= 1'b0;
            core_dat_q  <= 1'b0;
          end else begin
            core_dat_q <= ld_sr[0];
            ld_sr      <= {1'b0, ld_sr[159:1]};
            cnt        <= cnt + 8'd1;
          end
        end
        S_WAIT_INIT: begin
          // busy is not yet meaningful in the first cycle after the load
          if ((tmr != TMR_LOAD) && !core_busy_i) begin
            state      <= S_READY;
            in_ready_q <= 1'b1;
          end else if (tmr == '0) begin
            state  <= S_ERR;
            err_q  <= 1'b1;
            idle_q <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_READY: begin
          if (stop_i) begin
            state      <= S_END;
            in_ready_q <= 1'b0;
            core_end_q <= 1'b1;
          end else if (strm.in_valid_i) begin
            state      <= S_SHIFT;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            core_vld_q <= 1'b1;
            core_dat_q <= strm.in_dat_i[0];
            word_sr    <= {1'b0, strm.in_dat_i[31:1]};
          end
        end
        S_SHIFT: begin
          if (cnt < 8'd31) begin
            core_dat_q <= word_sr[0];
            word_sr    <= {1'b0, word_sr[31:1]};
          end else begin
            core_vld_q <= 1'b0;
            core_dat_q <= 1'b0;
          end
          if (cnt >= CAP_FIRST) begin
            out_dat_q <= {core_q, out_dat_q[31:1]};
          end
          if (cnt == SHIFT_LAST) begin
            state <= S_HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HOLD: begin
          if (!out_valid_q) begin
            out_dat_q   <= {core_q, out_dat_q[31:1]};
            out_valid_q <= 1'b1;
          end else if (strm.out_ready_i) begin
            state       <= S_READY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        S_END: begin
          state      <= S_IDLE;
          core_end_q <= 1'b0;
          idle_q     <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
